stack_alu_seq: RTL and testbench

Clocked, parametrised successor to the team's stack-based ALU: a DEPTH-entry LIFO operand stack of DATA_WIDTH-bit two's-complement words with push/pop/dup/swap and add/sub/mul acting on the top two entries. Commands arrive over a valid/ready handshake. Multiply is iterative (one partial product per cycle). Every completed command produces a one-cycle result strobe carrying data, signed-overflow and stack-error flags. The block sits between the instruction decoder and the result bus, replacing the combinational ALU in wide/deep configurations.

---
 rtl/stack_alu_seq_if.sv | 32 +++
 rtl/stack_alu_seq.sv | 192 +++++++++++++++++++
 tb/tb_stack_alu_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_alu_seq_if.sv
// Command/result bundle for the sequential stack ALU.
// The decoder drives master and the ALU is the slave.
interface stack_alu_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            opcode;
    logic [DATA_WIDTH-1:0] input_data;
    logic [DATA_WIDTH-1:0] output_data;
    logic                  out_valid;
    logic                  overflow;
    logic                  stack_error;
    logic                  empty;
    logic                  full;
    logic [CW-1:0]         count;

    modport master (
        output op_valid, opcode, input_data,
        input  op_ready, output_data, out_valid,
        input  overflow, stack_error, empty, full, count
    );

    modport slave (
        input  op_valid, opcode, input_data,
        output op_ready, output_data, out_valid,
        output overflow, stack_error, empty, full, count
    );
endinterface

// File: rtl/stack_alu_seq.sv
// LIFO operand stack with add/sub and an iterative
// shift-add signed multiplier, one partial product per cycle.
module stack_alu_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    stack_alu_seq_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = $clog2(W);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_DUP  = 3'b010;
    localparam logic [2:0] OP_SWAP = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t          state_q;
    logic [W-1:0]    stk_q [DEPTH];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    out_q;
    logic            ovf_q, err_q, vld_q;
    logic [2*W-1:0]  acc_q, mcd_q, acc_n, pp;
    logic [W-1:0]    mpl_q;
    logic [IW-1:0]   idx_q;

    logic [AW-1:0]   ia, ib, ip;
    logic [W-1:0]    a, b, sum, dif, res;
    logic            add_ovf, sub_ovf, ovf_c, mul_ovf;
    logic            has1, has2, full_w, legal, last;
    logic            we0, we1;
    logic [AW-1:0]   wa0, wa1;
    logic [W-1:0]    wd0, wd1;

    assign ib = AW'(cnt_q - 1'b1);
    assign ia = AW'(cnt_q - CW'(2));
    assign ip = AW'(cnt_q);
    assign a  = stk_q[ia];
    assign b  = stk_q[ib];

    assign sum     = a + b;
    assign dif     = a - b;
    assign add_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    assign sub_ovf = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);

    // The multiplier MSB carries negative weight, so it is subtracted.
    assign last    = idx_q == IW'(W - 1);
    assign pp      = mpl_q[0] ? mcd_q : '0;
    assign acc_n   = last ? acc_q - pp : acc_q + pp;
    assign mul_ovf = !((&acc_n[2*W-1:W-1]) || !(|acc_n[2*W-1:W-1]));

    assign has1   = cnt_q != '0;
    assign has2   = cnt_q >= CW'(2);
    assign full_w = cnt_q == CW'(DEPTH);

    always_comb begin
        legal = 1'b1;
        res   = out_q;
        ovf_c = 1'b0;
        cnt_d = cnt_q;
        we0   = 1'b0;
        we1   = 1'b0;
        wa0   = ip;
        wd0   = bus.input_data;
        wa1   = ia;
        wd1   = b;
        unique case (bus.opcode)
            OP_NOP: legal = 1'b1;
            OP_PUSH: begin
                legal = !full_w;
                res   = bus.input_data;
                cnt_d = cnt_q + 1'b1;
                we0   = legal;
            end
            OP_POP: begin
                legal = has1;
                res   = b;
                cnt_d = cnt_q - 1'b1;
            end
            OP_DUP: begin
                legal = has1 && !full_w;
                res   = b;
                wd0   = b;
                cnt_d = cnt_q + 1'b1;
                we0   = legal;
            end
            OP_SWAP: begin
                legal = has2;
                res   = a;
                wa0   = ib;
                wd0   = a;
                we0   = legal;
                we1   = legal;
            end
            OP_ADD, OP_SUB: begin
                legal = has2;
                res   = (bus.opcode == OP_ADD) ? sum : dif;
                ovf_c = (bus.opcode == OP_ADD) ? add_ovf : sub_ovf;
                cnt_d = cnt_q - 1'b1;
                wa0   = ia;
                wd0   = res;
                we0   = legal;
            end
            OP_MUL: legal = has2;
        endcase
        if (!(state_q == IDLE && bus.op_valid)) begin
            we0 = 1'b0;
            we1 = 1'b0;
        end
        if (state_q == MUL && last) begin
            we0 = 1'b1;
            wa0 = ia;
            wd0 = acc_n[W-1:0];
        end
    end

    // Stack storage has no reset; count alone defines valid entries.
    always_ff @(posedge clk) begin
        if (we0) stk_q[wa0] <= wd0;
        if (we1) stk_q[wa1] <= wd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            acc_q   <= '0;
            mcd_q   <= '0;
            mpl_q   <= '0;
            idx_q   <= '0;
        end else begin
            vld_q <= 1'b0;
            unique case (state_q)
                IDLE: if (bus.op_valid && bus.opcode != OP_NOP) begin
                    if (!legal) begin
                        vld_q <= 1'b1;
                        err_q <= 1'b1;
                        ovf_q <= 1'b0;
                    end else if (bus.opcode == OP_MUL) begin
                        state_q <= MUL;
                        acc_q   <= '0;
                        mcd_q   <= {{W{a[W-1]}}, a};
                        mpl_q   <= b;
                        idx_q   <= '0;
                    end else begin
                        vld_q <= 1'b1;
                        err_q <= 1'b0;
                        ovf_q <= ovf_c;
                        out_q <= res;
                        cnt_q <= cnt_d;
                    end
                end
                MUL: begin
                    acc_q <= acc_n;
                    mcd_q <= mcd_q << 1;
                    mpl_q <= mpl_q >> 1;
                    idx_q <= idx_q + 1'b1;
                    if (last) begin
                        state_q <= IDLE;
                        vld_q   <= 1'b1;
                        err_q   <= 1'b0;
                        ovf_q   <= mul_ovf;
                        out_q   <= acc_n[W-1:0];
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.op_ready    = state_q == IDLE;
    assign bus.output_data = out_q;
    assign bus.out_valid   = vld_q;
    assign bus.overflow    = ovf_q;
    assign bus.stack_error = err_q;
    assign bus.empty       = cnt_q == '0;
    assign bus.full        = full_w;
    assign bus.count       = cnt_q;
endmodule

// File: tb/tb_stack_alu_seq.sv
// Directed bench for stack_alu_seq at widths 4, 8 and 16,
// with a queue of expected completions per command.
module tb_stack_alu_seq;
    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] DUP  = 3'b010;
    localparam logic [2:0] SWAP = 3'b011;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v   [3];
    logic [2:0]  opc [3];
    logic [15:0] din [3];
    logic        rdy [3], ov [3], ovf [3], err [3], emp [3], ful [3];
    logic [3:0]  cnt [3];
    logic [15:0] od  [3];

    stack_alu_seq_if #(.DATA_WIDTH(4),  .DEPTH(8)) b4  ();
    stack_alu_seq_if #(.DATA_WIDTH(8),  .DEPTH(8)) b8  ();
    stack_alu_seq_if #(.DATA_WIDTH(16), .DEPTH(8)) b16 ();

    stack_alu_seq #(.DATA_WIDTH(4),  .DEPTH(8)) u4  (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave));
    stack_alu_seq #(.DATA_WIDTH(8),  .DEPTH(8)) u8  (
        .clk(clk), .rst_n(rst_n), .bus(b8.slave));
    stack_alu_seq #(.DATA_WIDTH(16), .DEPTH(8)) u16 (
        .clk(clk), .rst_n(rst_n), .bus(b16.slave));

    assign b4.op_valid    = v[0];
    assign b4.opcode      = opc[0];
    assign b4.input_data  = din[0][3:0];
    assign b8.op_valid    = v[1];
    assign b8.opcode      = opc[1];
    assign b8.input_data  = din[1][7:0];
    assign b16.op_valid   = v[2];
    assign b16.opcode     = opc[2];
    assign b16.input_data = din[2];

    assign rdy[0] = b4.op_ready;    assign rdy[1] = b8.op_ready;
    assign rdy[2] = b16.op_ready;
    assign ov[0]  = b4.out_valid;   assign ov[1]  = b8.out_valid;
    assign ov[2]  = b16.out_valid;
    assign ovf[0] = b4.overflow;    assign ovf[1] = b8.overflow;
    assign ovf[2] = b16.overflow;
    assign err[0] = b4.stack_error; assign err[1] = b8.stack_error;
    assign err[2] = b16.stack_error;
    assign emp[0] = b4.empty;       assign emp[1] = b8.empty;
    assign emp[2] = b16.empty;
    assign ful[0] = b4.full;        assign ful[1] = b8.full;
    assign ful[2] = b16.full;
    assign cnt[0] = b4.count;       assign cnt[1] = b8.count;
    assign cnt[2] = b16.count;
    assign od[0]  = {12'h000, b4.output_data};
    assign od[1]  = {8'h00, b8.output_data};
    assign od[2]  = b16.output_data;

    typedef struct {
        logic [15:0] d;
        logic        o;
        logic        e;
        int          bsy;
    } exp_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic cmd(input int s, input logic [2:0] op,
                       input logic [15:0] d, input logic [15:0] ed,
                       input logic eo, input logic ee, input int eb,
                       input string tag);
        exp_t e;
        int   n;
        int   busy;
        sb.push_back('{d: ed, o: eo, e: ee, bsy: eb});
        v[s]   = 1'b1;
        opc[s] = op;
        din[s] = d;
        @(posedge clk);
        @(negedge clk);
        v[s]   = 1'b0;
        opc[s] = 3'($urandom);
        din[s] = 16'($urandom);
        busy   = 0;
        n      = 0;
        while (!ov[s] && n < 40) begin
            if (!rdy[s]) busy++;
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, 16'(n < 40), 16'd1);
        e = sb.pop_front();
        if (n < 40) begin
            chk({tag, " data"}, od[s], e.d);
            chk({tag, " ovf"}, 16'(ovf[s]), 16'(e.o));
            chk({tag, " err"}, 16'(err[s]), 16'(e.e));
            chk({tag, " busy"}, 16'(busy), 16'(e.bsy));
        end
        @(negedge clk);
        chk({tag, " strobe"}, 16'(ov[s]), 16'd0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 3; i++) begin
            v[i]   = 1'b0;
            opc[i] = NOP;
            din[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst rdy", 16'(rdy[i]), 16'd1);
            chk("rst ov",  16'(ov[i]),  16'd0);
            chk("rst od",  od[i],       16'h0000);
            chk("rst ovf", 16'(ovf[i]), 16'd0);
            chk("rst err", 16'(err[i]), 16'd0);
            chk("rst emp", 16'(emp[i]), 16'd1);
            chk("rst ful", 16'(ful[i]), 16'd0);
            chk("rst cnt", 16'(cnt[i]), 16'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        cmd(0, PUSH, 16'h3, 16'h3, 0, 0, 0, "w4 push3");
        cmd(0, PUSH, 16'h4, 16'h4, 0, 0, 0, "w4 push4");
        cmd(0, ADD,  16'h0, 16'h7, 0, 0, 0, "w4 add");
        chk("w4 cnt", 16'(cnt[0]), 16'd1);

        cmd(1, PUSH, 16'hEB, 16'hEB, 0, 0, 0, "w8 push");
        cmd(1, PUSH, 16'h0A, 16'h0A, 0, 0, 0, "w8 push");
        cmd(1, MUL,  16'h0,  16'h2E, 1, 0, 8, "w8 mul");
        chk("w8 cnt", 16'(cnt[1]), 16'd1);
        cmd(1, POP,  16'h0,  16'h2E, 0, 0, 0, "w8 pop");
        cmd(1, PUSH, 16'h01, 16'h01, 0, 0, 0, "w8 push1");
        cmd(1, MUL,  16'h0,  16'h01, 0, 1, 0, "w8 mul c1");
        chk("w8 cnt c1", 16'(cnt[1]), 16'd1);

        cmd(2, PUSH, 16'h5FFE, 16'h5FFE, 0, 0, 0, "add pa");
        cmd(2, PUSH, 16'h5FFE, 16'h5FFE, 0, 0, 0, "add pb");
        cmd(2, ADD,  16'h0,    16'hBFFC, 1, 0, 0, "add ovf");
        cmd(2, PUSH, 16'h0001, 16'h0001, 0, 0, 0, "sub pb");
        cmd(2, SUB,  16'h0,    16'hBFFB, 0, 0, 0, "sub");
        chk("sub cnt", 16'(cnt[2]), 16'd1);
        cmd(2, POP,  16'h0,    16'hBFFB, 0, 0, 0, "pop res");
        cmd(2, POP,  16'h0,    16'hBFFB, 0, 1, 0, "pop empty");
        chk("pop empty cnt", 16'(cnt[2]), 16'd0);

        for (int i = 0; i < 8; i++)
            cmd(2, PUSH, 16'(16'h100 + i), 16'(16'h100 + i),
                0, 0, 0, "fill");
        chk("full", 16'(ful[2]), 16'd1);
        chk("full cnt", 16'(cnt[2]), 16'd8);
        cmd(2, PUSH, 16'hDEAD, 16'h0107, 0, 1, 0, "push full");
        cmd(2, POP,  16'h0,    16'h0107, 0, 0, 0, "top kept");
        cmd(2, DUP,  16'h0,    16'h0106, 0, 0, 0, "dup");
        cmd(2, DUP,  16'h0,    16'h0106, 0, 1, 0, "dup full");
        for (int i = 0; i < 8; i++)
            cmd(2, POP, 16'h0, (i == 0) ? 16'h0106 : 16'(16'h107 - i),
                0, 0, 0, "drain");
        chk("drain emp", 16'(emp[2]), 16'd1);

        cmd(2, PUSH, 16'h5, 16'h5, 0, 0, 0, "sw p5");
        cmd(2, PUSH, 16'h9, 16'h9, 0, 0, 0, "sw p9");
        cmd(2, SWAP, 16'h0, 16'h5, 0, 0, 0, "swap");
        cmd(2, POP,  16'h0, 16'h5, 0, 0, 0, "sw pop5");
        cmd(2, POP,  16'h0, 16'h9, 0, 0, 0, "sw pop9");

        cmd(2, PUSH, 16'h22, 16'h22, 0, 0, 0, "c1 push");
        cmd(2, ADD,  16'h0,  16'h22, 0, 1, 0, "add c1");
        cmd(2, MUL,  16'h0,  16'h22, 0, 1, 0, "mul c1");
        cmd(2, POP,  16'h0,  16'h22, 0, 0, 0, "c1 pop");

        cmd(2, PUSH, 16'h0007, 16'h0007, 0, 0, 0, "m16 pa");
        cmd(2, PUSH, 16'hFFFD, 16'hFFFD, 0, 0, 0, "m16 pb");
        cmd(2, MUL,  16'h0,    16'hFFEB, 0, 0, 16, "m16 mul");

        v[2]   = 1'b1;
        opc[2] = NOP;
        @(posedge clk);
        @(negedge clk);
        v[2] = 1'b0;
        seen = 0;
        repeat (3) begin
            if (ov[2]) seen = 1;
            @(negedge clk);
        end
        chk("nop strobe", 16'(seen), 16'd0);
        chk("nop cnt", 16'(cnt[2]), 16'd1);

        cmd(1, PUSH, 16'h03, 16'h03, 0, 0, 0, "ab push");
        chk("ab cnt", 16'(cnt[1]), 16'd2);
        v[1]   = 1'b1;
        opc[1] = MUL;
        @(posedge clk);
        @(negedge clk);
        v[1] = 1'b0;
        seen = 0;
        repeat (2) begin
            if (ov[1]) seen = 1;
            @(negedge clk);
        end
        chk("ab busy", 16'(rdy[1]), 16'd0);
        rst_n = 1'b0;
        #1;
        chk("ab rdy", 16'(rdy[1]), 16'd1);
        chk("ab cnt0", 16'(cnt[1]), 16'd0);
        chk("ab emp", 16'(emp[1]), 16'd1);
        repeat (2) begin
            if (ov[1]) seen = 1;
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (12) begin
            if (ov[1]) seen = 1;
            @(negedge clk);
        end
        chk("ab no strobe", 16'(seen), 16'd0);
        chk("ab od", od[1], 16'h0000);
        chk("ab cnt", 16'(cnt[1]), 16'd0);
        cmd(1, PUSH, 16'h55, 16'h55, 0, 0, 0, "ab next");
        chk("sb empty", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
